// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
// Lets NREQ local requesters share one AHB-Lite master port. Each requester
// offers single read/write commands on a valid/ready handshake. A round-robin
// arbiter accepts one command at a time and issues it as a single NONSEQ
// transfer. Only one transfer is in flight at any time. Each completion is
// reported to its requester as a one-cycle response pulse.
module ahb_master_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 32,
   parameter int DW   = 32
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*3-1:0] req_size,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic [AW-1:0]     haddr,
   output logic [1:0]        htrans,
   output logic [2:0]        hsize,
   output logic              hwrite,
   output logic [DW-1:0]     hwdata,
   input  logic [DW-1:0]     hrdata,
   input  logic              hready,
   input  logic              hresp
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [LW-1:0] LAST_INIT = LW'(NREQ - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic [1:0]    state;
   logic [LW-1:0] last;
   logic [LW-1:0] owner;
   logic [LW-1:0] grant_idx;
   logic          grant_found;
   logic          accept;

   logic [AW-1:0] sel_addr;
   logic [2:0]    sel_size;
   logic          sel_write;
   logic [DW-1:0] sel_wdata;

   // Round-robin search: first valid requester after the last one granted,
   // wrapping around, so that the most recent winner has lowest priority.
   always_comb begin
      int cand;
      logic [LW-1:0] cand_idx;
      grant_found = 1'b0;
      grant_idx   = last;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = cand[LW-1:0];
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // A command is taken only while idle and never during reset, so a
   // requester can never see a handshake that the reset then discards.
   assign accept = (state == ST_IDLE) && grant_found && !hreset;

   // The ready strobe is one-hot on the winner and only while idle.
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Pick the winning requester's fields out of the flattened buses.
   assign sel_addr  = req_addr[grant_idx*AW +: AW];
   assign sel_size  = req_size[grant_idx*3 +: 3];
   assign sel_write = req_write[grant_idx];
   assign sel_wdata = req_wdata[grant_idx*DW +: DW];

   // NONSEQ is shown only during the address phase; every other cycle is IDLE.
   assign htrans = (state == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;

   // Transfer sequencing: idle -> address phase -> data phase -> idle,
   // with both bus phases stretched for as long as hready stays low.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state <= ST_IDLE;
         last  <= LAST_INIT;
         owner <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_ADDR;
                  last  <= grant_idx;
                  owner <= grant_idx;
               end
            end
            ST_ADDR: begin
               if (hready) begin
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (hready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // The accepted command is captured once and held until the next one.
   // That keeps the address-phase signals stable through wait states and
   // write data present for the whole data phase, for reads as well.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         haddr  <= '0;
         hsize  <= '0;
         hwrite <= 1'b0;
         hwdata <= '0;
      end else if (accept) begin
         haddr  <= sel_addr;
         hsize  <= sel_size;
         hwrite <= sel_write;
         hwdata <= sel_wdata;
      end
   end

   // Completion: when the data phase ends, capture the slave's data and error
   // status and pulse the owner's response bit for exactly one cycle. A
   // transfer cut short by reset never produces a response.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if ((state == ST_DATA) && hready) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= hrdata;
            rsp_err          <= hresp;
         end
      end
   end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter
// Checks ahb_master_arbiter cycle by cycle against a transaction-level model
// of the arbiter: a round-robin pointer, the command currently on the bus and
// the bus phase it is in. Directed scenarios run first, then random traffic.
module tb_ahb_master_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;

   logic              hclk;
   logic              hreset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*3-1:0] req_size;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic [AW-1:0]     haddr;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic              hwrite;
   logic [DW-1:0]     hwdata;
   logic [DW-1:0]     hrdata;
   logic              hready;
   logic              hresp;

   ahb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .hclk(hclk), .hreset(hreset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
      .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
   );

   // 10 ns clock
   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   int checks = 0;
   int errors = 0;

   // Reference model: bus phase 0 = nothing on the bus, 1 = address phase,
   // 2 = data phase; plus the command on the bus and the pending response.
   int              m_phase;
   int              m_last;
   int              m_owner;
   logic [AW-1:0]   m_addr;
   logic [2:0]      m_size;
   logic            m_write;
   logic [DW-1:0]   m_wdata;
   bit              m_rsp;
   int              m_rsp_owner;
   logic [DW-1:0]   m_rdata;
   logic            m_err;
   logic [NREQ-1:0] m_accepted;
   int              accept_log[$];

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_phase     = 0;
      m_last      = NREQ - 1;
      m_owner     = 0;
      m_addr      = '0;
      m_size      = '0;
      m_write     = 1'b0;
      m_wdata     = '0;
      m_rsp       = 1'b0;
      m_rsp_owner = 0;
      m_rdata     = '0;
      m_err       = 1'b0;
   endtask

   // Round-robin rule: first valid requester at last+1, last+2, ... mod NREQ.
   function automatic int rr_pick();
      for (int k = 1; k <= NREQ; k++) begin
         if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [2:0] s,
                          input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_size[i*3 +: 3]    = s;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic drive_bus(input logic rdy, input logic err, input logic [DW-1:0] rd);
      hready = rdy;
      hresp  = err;
      hrdata = rd;
   endtask

   // Randomized requester and slave behaviour. A requester holds its command
   // until accepted and may withdraw it beforehand when allow_drop is set.
   task automatic applyStimulus(input int p_valid, input int p_ready,
                                input int p_err, input bit allow_drop);
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && !m_accepted[i]) begin
            if (allow_drop && ($urandom_range(99) < 5)) req_valid[i] = 1'b0;
         end else begin
            set_req(i, ($urandom_range(99) < p_valid), 1'($urandom), $urandom,
                    3'($urandom_range(2)), $urandom);
         end
      end
      drive_bus(($urandom_range(99) < p_ready), ($urandom_range(99) < p_err), $urandom);
   endtask

   // Compare every output with the model at the falling edge, then advance
   // the model by the rising edge that follows, using the inputs now applied.
   task automatic run_cycle();
      logic [NREQ-1:0] exp_ready;
      logic [NREQ-1:0] exp_rsp;
      int g;
      @(negedge hclk);
      exp_ready = '0;
      g = -1;
      if (!hreset && (m_phase == 0)) begin
         g = rr_pick();
         if (g >= 0) exp_ready[g] = 1'b1;
      end
      exp_rsp = '0;
      if (m_rsp) exp_rsp[m_rsp_owner] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
      checkOutput("htrans", 64'(htrans), (m_phase == 1) ? 64'h2 : 64'h0);
      checkOutput("haddr", 64'(haddr), 64'(m_addr));
      checkOutput("hsize", 64'(hsize), 64'(m_size));
      checkOutput("hwrite", 64'(hwrite), 64'(m_write));
      checkOutput("hwdata", 64'(hwdata), 64'(m_wdata));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      if (m_rsp) begin
         checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
         checkOutput("rsp_err", 64'(rsp_err), 64'(m_err));
      end
      m_accepted = '0;
      if (hreset) begin
         model_reset();
      end else begin
         m_rsp = 1'b0;
         if (m_phase == 0) begin
            if (g >= 0) begin
               m_addr   = req_addr[g*AW +: AW];
               m_size   = req_size[g*3 +: 3];
               m_write  = req_write[g];
               m_wdata  = req_wdata[g*DW +: DW];
               m_owner  = g;
               m_last   = g;
               m_phase  = 1;
               m_accepted[g] = 1'b1;
               accept_log.push_back(g);
            end
         end else if (m_phase == 1) begin
            if (hready) m_phase = 2;
         end else begin
            if (hready) begin
               m_rsp       = 1'b1;
               m_rsp_owner = m_owner;
               m_rdata     = hrdata;
               m_err       = hresp;
               m_phase     = 0;
            end
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         req_valid = '0;
         drive_bus(1'b1, 1'b0, '0);
         run_cycle();
      end
   endtask

   task automatic reset_cycle();
      step();
      hreset = 1'b1;
      run_cycle();
      step();
      hreset = 1'b0;
   endtask

   initial begin
      hreset    = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_size  = '0;
      req_wdata = '0;
      drive_bus(1'b0, 1'b0, '0);
      m_accepted = '0;
      step();
      model_reset();
      run_cycle();
      checkOutput("reset_htrans", 64'(htrans), 64'h0);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);

      // Zero-wait write from requester 0
      step();
      hreset = 1'b0;
      set_req(0, 1'b1, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
      drive_bus(1'b1, 1'b0, '0);
      run_cycle();
      checkOutput("t1_ready", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      run_cycle();
      checkOutput("t1_htrans", 64'(htrans), 64'h2);
      checkOutput("t1_haddr", 64'(haddr), 64'h100);
      checkOutput("t1_hwrite", 64'(hwrite), 64'h1);
      step();
      run_cycle();
      checkOutput("t1_hwdata", 64'(hwdata), 64'hDEADBEEF);
      step();
      run_cycle();
      checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'h1);
      checkOutput("t1_rsp_err", 64'(rsp_err), 64'h0);

      // Read from requester 2 with two data-phase wait states
      step();
      set_req(2, 1'b1, 1'b0, 32'h40, 3'd2, 32'h0);
      run_cycle();
      step();
      req_valid = '0;
      run_cycle();
      for (int k = 0; k < 2; k++) begin
         step();
         drive_bus(1'b0, 1'b0, '0);
         run_cycle();
         checkOutput("t2_no_rsp", 64'(rsp_valid), 64'h0);
      end
      step();
      drive_bus(1'b1, 1'b0, 32'h12345678);
      run_cycle();
      step();
      run_cycle();
      checkOutput("t2_rsp_valid", 64'(rsp_valid), 64'h4);
      checkOutput("t2_rsp_rdata", 64'(rsp_rdata), 64'h12345678);

      // Address-phase waits on a write from requester 1 while 0 also requests
      step();
      set_req(1, 1'b1, 1'b1, 32'hA0, 3'd2, 32'h55AA55AA);
      run_cycle();
      checkOutput("t4_ready", 64'(req_ready), 64'h2);
      step();
      req_valid = '0;
      set_req(0, 1'b1, 1'b0, 32'h200, 3'd1, 32'h0);
      drive_bus(1'b0, 1'b0, '0);
      for (int k = 0; k < 3; k++) begin
         run_cycle();
         checkOutput("t4_htrans", 64'(htrans), 64'h2);
         checkOutput("t4_haddr", 64'(haddr), 64'hA0);
         checkOutput("t4_hwrite", 64'(hwrite), 64'h1);
         checkOutput("t4_ready", 64'(req_ready), 64'h0);
         step();
      end
      drive_bus(1'b1, 1'b0, '0);
      run_cycle();
      step();
      run_cycle();
      idle_cycles(6);

      // Error response on a read from requester 3
      step();
      set_req(3, 1'b1, 1'b0, 32'h300, 3'd2, 32'h0);
      run_cycle();
      step();
      req_valid = '0;
      run_cycle();
      step();
      drive_bus(1'b0, 1'b1, '0);
      run_cycle();
      step();
      drive_bus(1'b1, 1'b1, 32'hCAFE0000);
      run_cycle();
      step();
      drive_bus(1'b1, 1'b0, '0);
      run_cycle();
      checkOutput("t5_rsp_valid", 64'(rsp_valid), 64'h8);
      checkOutput("t5_rsp_err", 64'(rsp_err), 64'h1);
      checkOutput("t5_htrans", 64'(htrans), 64'h0);

      // Fairness: everyone requesting continuously, zero-wait slave
      reset_cycle();
      accept_log.delete();
      m_accepted = '0;
      for (int k = 0; k < 36; k++) begin
         if (k > 0) step();
         applyStimulus(100, 100, 0, 1'b0);
         run_cycle();
      end
      checkOutput("t3_count", 64'(accept_log.size()), 64'd12);
      for (int k = 0; k < 12; k++) begin
         checkOutput($sformatf("t3_grant_%0d", k),
                     64'((k < accept_log.size()) ? accept_log[k] : -1), 64'(k % 4));
      end
      idle_cycles(4);

      // Reset during the data phase of a requester 1 write
      step();
      set_req(1, 1'b1, 1'b1, 32'h1A0, 3'd2, 32'h0BADF00D);
      run_cycle();
      step();
      req_valid = '0;
      run_cycle();
      step();
      hreset = 1'b1;
      run_cycle();
      step();
      hreset = 1'b0;
      req_valid = '1;
      run_cycle();
      checkOutput("t6_htrans", 64'(htrans), 64'h0);
      checkOutput("t6_haddr", 64'(haddr), 64'h0);
      checkOutput("t6_hwdata", 64'(hwdata), 64'h0);
      checkOutput("t6_rsp_valid", 64'(rsp_valid), 64'h0);
      checkOutput("t6_first_grant", 64'(req_ready), 64'h1);
      idle_cycles(4);

      // Random traffic with occasional resets
      m_accepted = '0;
      for (int k = 0; k < 3000; k++) begin
         step();
         hreset = ($urandom_range(299) == 0);
         applyStimulus(40, 70, 20, 1'b1);
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
